// File: rtl/sram_bridge_pkg.sv
// Shared types and constants for the 32-bit bus to 16-bit async SRAM bridge.
// Optional feature macro: SRAM_BRIDGE_SKIP_EN (skips halves with no byte lanes selected).
package sram_bridge_pkg;

   localparam int unsigned SRAM_AW = 18;
   localparam int unsigned SRAM_DW = 16;
   localparam int unsigned BUS_AW  = 17;

   // Idle levels of the active-low SRAM control pins
   localparam logic       CTL_INACTIVE = 1'b1;
   localparam logic [1:0] BE_INACTIVE  = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      HI_SETUP,
      HI_STROBE,
      LO_SETUP,
      LO_STROBE,
      ACK
   } sram_state_t;

endpackage

// File: rtl/sram_bridge_if.sv
// CPU-side bus of the SRAM bridge: the CPU is the master, the bridge the slave.
interface sram_bridge_if;
   import sram_bridge_pkg::*;

   logic [BUS_AW-1:0] adr_i;
   logic [31:0]       dat_i;
   logic [31:0]       dat_o;
   logic              stb_i;
   logic              cyc_i;
   logic              we_i;
   logic [3:0]        sel_i;
   logic              ack_o;

   modport master (
      output adr_i, dat_i, stb_i, cyc_i, we_i, sel_i,
      input  dat_o, ack_o
   );

   modport slave (
      input  adr_i, dat_i, stb_i, cyc_i, we_i, sel_i,
      output dat_o, ack_o
   );

endinterface

// File: rtl/sram_bridge.sv
// Splits each 32-bit bus cycle into two timed 16-bit async SRAM accesses,
// high halfword first, finishing with a one-cycle ack. All SRAM pins are
// registered from the next-state values so they never glitch.
// Optional feature macro: SRAM_BRIDGE_SKIP_EN.
module sram_bridge
   import sram_bridge_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic               sysclock,
   input  logic               rst_i,
   sram_bridge_if.slave       bus,
   output logic [SRAM_AW-1:0] addrbus_out,
   input  logic [SRAM_DW-1:0] databus_in,
   output logic [SRAM_DW-1:0] databus_out,
   output logic [1:0]         be_n,
   output logic               ce_n,
   output logic               oe_n,
   output logic               we_n
);

   localparam logic [3:0] STROBE_LOAD = 4'(WAIT_CYCLES - 1);

   sram_state_t        state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [BUS_AW-1:0]  adr_q, adr_d;
   logic [31:0]        dat_q, dat_d;
   logic [3:0]         sel_q, sel_d;
   logic               we_q, we_d;
   logic [31:0]        rdata_q, rdata_d;
   logic [31:0]        dato_q, dato_d;
   logic               ack_q, ack_d;
   logic [SRAM_AW-1:0] addr_q, addr_d;
   logic [SRAM_DW-1:0] dout_q, dout_d;
   logic [1:0]         be_q, be_d;
   logic               ce_q, ce_d;
   logic               oe_q, oe_d;
   logic               wen_q, wen_d;
   logic               accept, hi_run, lo_run;
   logic [1:0]         be_hi, be_lo;

   // Next-state, request latching, read capture and next SRAM pin levels
   always_comb begin
      accept  = (state_q == IDLE) && bus.cyc_i && bus.stb_i;
      adr_d   = accept ? bus.adr_i : adr_q;
      dat_d   = accept ? bus.dat_i : dat_q;
      sel_d   = accept ? bus.sel_i : sel_q;
      we_d    = accept ? bus.we_i  : we_q;
      rdata_d = accept ? '0        : rdata_q;
`ifdef SRAM_BRIDGE_SKIP_EN
      hi_run = |sel_d[3:2];
      lo_run = |sel_d[1:0];
      be_hi  = ~sel_d[3:2];
      be_lo  = ~sel_d[1:0];
`else
      hi_run = 1'b1;
      lo_run = 1'b1;
      be_hi  = we_d ? ~sel_d[3:2] : 2'b00;
      be_lo  = we_d ? ~sel_d[1:0] : 2'b00;
`endif
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = hi_run ? HI_SETUP : (lo_run ? LO_SETUP : ACK);
            end
         end
         HI_SETUP: begin
            state_d = HI_STROBE;
            cnt_d   = STROBE_LOAD;
         end
         HI_STROBE: begin
            if (cnt_q == '0) begin
               if (!we_q) rdata_d[31:16] = databus_in;
               state_d = lo_run ? LO_SETUP : ACK;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         LO_SETUP: begin
            state_d = LO_STROBE;
            cnt_d   = STROBE_LOAD;
         end
         LO_STROBE: begin
            if (cnt_q == '0) begin
               if (!we_q) rdata_d[15:0] = databus_in;
               state_d = ACK;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ACK: state_d = IDLE;
      endcase
      if ((state_q != IDLE) && !bus.cyc_i) begin
         state_d = IDLE;
         cnt_d   = '0;
      end

      // Pins follow the state being entered; address/be/data only move on SETUP entry
      ack_d  = 1'b0;
      dato_d = dato_q;
      addr_d = addr_q;
      dout_d = dout_q;
      be_d   = be_q;
      ce_d   = CTL_INACTIVE;
      oe_d   = CTL_INACTIVE;
      wen_d  = CTL_INACTIVE;
      case (state_d)
         HI_SETUP: begin
            ce_d   = 1'b0;
            addr_d = {adr_d, 1'b0};
            be_d   = be_hi;
            dout_d = dat_d[31:16];
         end
         LO_SETUP: begin
            ce_d   = 1'b0;
            addr_d = {adr_d, 1'b1};
            be_d   = be_lo;
            dout_d = dat_d[15:0];
         end
         HI_STROBE, LO_STROBE: begin
            ce_d  = 1'b0;
            oe_d  = we_d;
            wen_d = !we_d;
         end
         ACK: begin
            ack_d = 1'b1;
            if (!we_d) dato_d = rdata_d;
         end
         default: ;
      endcase
   end

   // State and registered outputs, asynchronously reset
   always_ff @(posedge sysclock or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         adr_q   <= '0;
         dat_q   <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
         dato_q  <= '0;
         ack_q   <= 1'b0;
         addr_q  <= '0;
         dout_q  <= '0;
         be_q    <= BE_INACTIVE;
         ce_q    <= CTL_INACTIVE;
         oe_q    <= CTL_INACTIVE;
         wen_q   <= CTL_INACTIVE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         sel_q   <= sel_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
         dato_q  <= dato_d;
         ack_q   <= ack_d;
         addr_q  <= addr_d;
         dout_q  <= dout_d;
         be_q    <= be_d;
         ce_q    <= ce_d;
         oe_q    <= oe_d;
         wen_q   <= wen_d;
      end
   end

   assign bus.ack_o   = ack_q;
   assign bus.dat_o   = dato_q;
   assign addrbus_out = addr_q;
   assign databus_out = dout_q;
   assign be_n        = be_q;
   assign ce_n        = ce_q;
   assign oe_n        = oe_q;
   assign we_n        = wen_q;

endmodule

// File: tb/tb_sram_bridge.sv
// Bench for sram_bridge: two instances (WAIT_CYCLES 1 and 3) each on a
// behavioural async SRAM; a scoreboard queue per instance checks dat_o at ack.
module tb_sram_bridge;

   logic sysclock = 1'b0;
   logic rst_i;
   always #5 sysclock = ~sysclock;

   sram_bridge_if b0();
   sram_bridge_if b1();

   logic [17:0] a0, a1;
   logic [15:0] di0, do0, di1, do1;
   logic [1:0]  be0, be1;
   logic        ce0, oe0, we0, ce1, oe1, we1;

   sram_bridge #(.WAIT_CYCLES(1)) u0 (
      .sysclock(sysclock), .rst_i(rst_i), .bus(b0.slave),
      .addrbus_out(a0), .databus_in(di0), .databus_out(do0),
      .be_n(be0), .ce_n(ce0), .oe_n(oe0), .we_n(we0)
   );

   sram_bridge #(.WAIT_CYCLES(3)) u1 (
      .sysclock(sysclock), .rst_i(rst_i), .bus(b1.slave),
      .addrbus_out(a1), .databus_in(di1), .databus_out(do1),
      .be_n(be1), .ce_n(ce1), .oe_n(oe1), .we_n(we1)
   );

   // SRAM models: combinational read, byte-enabled write while strobed
   logic [15:0] mem0 [0:1023];
   logic [15:0] mem1 [0:1023];
   logic        clr, pk_en, pk_inst;
   logic [9:0]  pk_a;
   logic [15:0] pk_d;

   assign di0 = (!ce0 && !oe0) ? mem0[a0[9:0]] : 16'hFFFF;
   assign di1 = (!ce1 && !oe1) ? mem1[a1[9:0]] : 16'hFFFF;

   always @(posedge sysclock) begin
      if (clr) begin
         for (int i = 0; i < 1024; i++) begin
            mem0[i] <= 16'h0000;
            mem1[i] <= 16'h0000;
         end
      end else if (pk_en) begin
         if (pk_inst) mem1[pk_a] <= pk_d;
         else         mem0[pk_a] <= pk_d;
      end else begin
         if (!ce0 && !we0) begin
            if (!be0[1]) mem0[a0[9:0]][15:8] <= do0[15:8];
            if (!be0[0]) mem0[a0[9:0]][7:0]  <= do0[7:0];
         end
         if (!ce1 && !we1) begin
            if (!be1[1]) mem1[a1[9:0]][15:8] <= do1[15:8];
            if (!be1[0]) mem1[a1[9:0]][7:0]  <= do1[7:0];
         end
      end
   end

   int checks = 0;
   int passed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   typedef struct {
      logic        rd;
      logic [31:0] d;
   } exp_t;
   exp_t q0[$];
   exp_t q1[$];
   logic [31:0] last0 = '0;
   logic [31:0] last1 = '0;

   // Scoreboard monitors: every ack pops one expectation
   always @(negedge sysclock) begin
      exp_t e;
      if (!rst_i && b0.ack_o) begin
         if (q0.size() == 0) chk("unexpected_ack0", 32'd1, 32'd0);
         else begin
            e = q0.pop_front();
            chk(e.rd ? "rd_data0" : "wr_dat_hold0", b0.dat_o, e.d);
         end
      end
      if (!rst_i && b1.ack_o) begin
         if (q1.size() == 0) chk("unexpected_ack1", 32'd1, 32'd0);
         else begin
            e = q1.pop_front();
            chk(e.rd ? "rd_data1" : "wr_dat_hold1", b1.dat_o, e.d);
         end
      end
   end

   // Strobe observer for the W=3 instance
   int   oe_hi, oe_lo, addr_chg;
   logic mon_clr;
   logic prev_low;
   logic [17:0] prev_a;
   always @(negedge sysclock) begin
      if (mon_clr) begin
         oe_hi = 0; oe_lo = 0; addr_chg = 0; prev_low = 1'b0;
      end else begin
         if (!oe1) begin
            if (a1[0]) oe_lo++;
            else       oe_hi++;
            if (prev_low && (a1 != prev_a)) addr_chg++;
         end
         prev_low = !oe1;
      end
      prev_a = a1;
   end

   function automatic logic ack_of(input int inst);
      return (inst == 0) ? b0.ack_o : b1.ack_o;
   endfunction

   task automatic drive(input int inst, input logic c, input logic w, input logic [16:0] adr,
                        input logic [31:0] d, input logic [3:0] sel);
      if (inst == 0) begin
         b0.cyc_i = c; b0.stb_i = c; b0.we_i = w; b0.adr_i = adr; b0.dat_i = d; b0.sel_i = sel;
      end else begin
         b1.cyc_i = c; b1.stb_i = c; b1.we_i = w; b1.adr_i = adr; b1.dat_i = d; b1.sel_i = sel;
      end
   endtask

   task automatic poke(input logic inst, input logic [9:0] a, input logic [15:0] d);
      @(negedge sysclock);
      pk_en = 1'b1; pk_inst = inst; pk_a = a; pk_d = d;
      @(negedge sysclock);
      pk_en = 1'b0;
   endtask

   // One bus cycle; lat is the cycle number in which ack was seen, -1 on timeout
   task automatic access(input int inst, input logic w, input logic [16:0] adr,
                         input logic [31:0] d, input logic [3:0] sel, output int lat);
      @(negedge sysclock);
      drive(inst, 1'b1, w, adr, d, sel);
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge sysclock);
         if (ack_of(inst)) begin
            lat = n;
            break;
         end
      end
      drive(inst, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic do_wr(input int inst, input logic [16:0] adr, input logic [31:0] d,
                        input logic [3:0] sel, input int exp_lat, input string name);
      int lat;
      if (inst == 0) q0.push_back('{1'b0, last0});
      else           q1.push_back('{1'b0, last1});
      access(inst, 1'b1, adr, d, sel, lat);
      chk(name, lat, exp_lat);
   endtask

   task automatic do_rd(input int inst, input logic [16:0] adr, input logic [31:0] exp_d,
                        input int exp_lat, input string name);
      int lat;
      if (inst == 0) begin q0.push_back('{1'b1, exp_d}); last0 = exp_d; end
      else           begin q1.push_back('{1'b1, exp_d}); last1 = exp_d; end
      access(inst, 1'b0, adr, '0, 4'hF, lat);
      chk(name, lat, exp_lat);
   endtask

   initial begin
      int n1, n2, acks;
      rst_i = 1'b1; clr = 1'b1; pk_en = 1'b0; pk_inst = 1'b0; pk_a = '0; pk_d = '0;
      mon_clr = 1'b1;
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0, '0);
      @(negedge sysclock);
      @(negedge sysclock);
      clr = 1'b0;
      chk("rst_ack", b0.ack_o, 1'b0);
      chk("rst_dat_o", b0.dat_o, 32'h0);
      chk("rst_ctl", {ce0, oe0, we0}, 3'b111);
      chk("rst_be", be0, 2'b11);
      chk("rst_addr", a0, 18'h0);
      rst_i = 1'b0;
      poke(0, 10'h000, 16'h1111);
      poke(0, 10'h001, 16'h2222);
      poke(0, 10'h002, 16'hA1A2);
      poke(0, 10'h003, 16'hB1B2);
      poke(0, 10'h004, 16'hC1C2);
      poke(0, 10'h005, 16'hD1D2);
      poke(1, 10'h006, 16'h0BAD);
      poke(1, 10'h007, 16'hF00D);

      // Full word write then read back, W=1
      do_wr(0, 17'h00010, 32'h12345678, 4'hF, 5, "wr_lat");
      chk("mem_020", mem0[10'h020], 16'h1234);
      chk("mem_021", mem0[10'h021], 16'h5678);
      do_rd(0, 17'h00010, 32'h12345678, 5, "rd_lat");

      // Single byte lane write: lane 2 lands in the low byte of halfword 0
`ifdef SRAM_BRIDGE_SKIP_EN
      do_wr(0, 17'h00000, 32'hAABBCCDD, 4'b0100, 3, "byte_wr_lat");
`else
      do_wr(0, 17'h00000, 32'hAABBCCDD, 4'b0100, 5, "byte_wr_lat");
`endif
      chk("byte_mem_000", mem0[10'h000], 16'h11BB);
      chk("byte_mem_001", mem0[10'h001], 16'h2222);

      // W=3 read timing on the second instance
      @(negedge sysclock);
      mon_clr = 1'b0;
      do_rd(1, 17'h00003, 32'h0BADF00D, 9, "w3_rd_lat");
      chk("w3_oe_hi", oe_hi, 3);
      chk("w3_oe_lo", oe_lo, 3);
      chk("w3_addr_stable", addr_chg, 0);

      // Abort a write during the HI strobe
      @(negedge sysclock);
      drive(0, 1'b1, 1'b1, 17'h00040, 32'hCAFEF00D, 4'hF);
      @(negedge sysclock);
      @(negedge sysclock);
      chk("abort_in_strobe", {ce0, we0}, 2'b00);
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      @(negedge sysclock);
      chk("abort_ctl", {ce0, oe0, we0}, 3'b111);
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         if (b0.ack_o) acks++;
         @(negedge sysclock);
      end
      chk("abort_no_ack", acks, 0);
      chk("abort_hi_written", mem0[10'h080], 16'hCAFE);
      chk("abort_lo_untouched", mem0[10'h081], 16'h0000);

      // Asynchronous reset during LO strobe of a read
      @(negedge sysclock);
      drive(0, 1'b1, 1'b0, 17'h00010, '0, 4'hF);
      for (int i = 0; i < 4; i++) @(negedge sysclock);
      chk("pre_rst_lo_strobe", {oe0, a0}, {1'b0, 18'h00021});
      #1 rst_i = 1'b1;
      #1;
      chk("mid_rst_ack", b0.ack_o, 1'b0);
      chk("mid_rst_dat_o", b0.dat_o, 32'h0);
      chk("mid_rst_ctl", {ce0, oe0, we0}, 3'b111);
      chk("mid_rst_be", be0, 2'b11);
      chk("mid_rst_addr", a0, 18'h0);
      chk("mid_rst_dout", do0, 16'h0);
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      last0 = '0;
      @(negedge sysclock);
      rst_i = 1'b0;
      do_rd(0, 17'h00010, 32'h12345678, 5, "post_rst_rd_lat");

      // Back-to-back reads with strobe held
      q0.push_back('{1'b1, 32'hA1A2B1B2});
      q0.push_back('{1'b1, 32'hC1C2D1D2});
      last0 = 32'hC1C2D1D2;
      @(negedge sysclock);
      drive(0, 1'b1, 1'b0, 17'h00001, '0, 4'hF);
      n1 = -1; n2 = -1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge sysclock);
         if (b0.ack_o) begin
            if (n1 < 0) begin
               n1 = n;
               b0.adr_i = 17'h00002;
            end else begin
               n2 = n;
               break;
            end
         end
      end
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      chk("b2b_first_lat", n1, 5);
      chk("b2b_spacing", n2 - n1, 6);

      for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge sysclock);
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
